// File: rtl/frodo_seq_pkg.sv
// Shared state encoding, mode constants and packed-table slicing helpers for the Frodo instruction sequencer.
package frodo_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_IF     = 3'd2,
    S_EX     = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [1:0] MODE_KEYGEN = 2'd0;
  localparam logic [1:0] MODE_ENCAP  = 2'd1;
  localparam logic [1:0] MODE_DECAP  = 2'd2;

  localparam int TBL_MAX_W = 256;
  localparam int PC_MAX_W  = 32;

  // Field idx of width w from a packed table, entry 0 in the LSBs.
  function automatic logic [PC_MAX_W-1:0] tbl_slice(input logic [TBL_MAX_W-1:0] tbl,
                                                    input int idx, input int w);
    logic [TBL_MAX_W-1:0] sh;
    logic [PC_MAX_W:0]    mask;
    sh   = tbl >> (idx * w);
    mask = ((PC_MAX_W+1)'(1) << w) - (PC_MAX_W+1)'(1);
    return sh[PC_MAX_W-1:0] & mask[PC_MAX_W-1:0];
  endfunction

  function automatic logic [PC_MAX_W-1:0] entry_of(input logic [TBL_MAX_W-1:0] tbl,
                                                   input int mode, input int w);
    return tbl_slice(tbl, mode, w);
  endfunction

  function automatic logic [PC_MAX_W-1:0] last_of(input logic [TBL_MAX_W-1:0] tbl,
                                                  input int mode, input int w);
    return tbl_slice(tbl, mode, w);
  endfunction

endpackage

// File: rtl/frodo_seq_wdog.sv
// EX-state watchdog: cleared on EX entry, counts EX cycles without inst_done,
// o_exp flags the cycle in which the counter reaches all-ones.
module frodo_seq_wdog #(
  parameter int W = 12
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_exp
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_exp = i_inc && (r_cnt == {{(W-1){1'b1}}, 1'b0});

endmodule

// File: rtl/frodo_seq_ctrl.sv
// Frodo KEM instruction sequencer: runs the per-mode PC range entry..last, one fetch per instruction, gated by inst_done.
// Optional EX watchdog enabled by defining FRODO_SEQ_WDOG_EN.
module frodo_seq_ctrl
  import frodo_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int MODE_W = 2,
  parameter logic [(2**MODE_W)*PC_W-1:0] PC_ENTRY = {8'd255, 8'd16, 8'd8, 8'd0},
  parameter logic [(2**MODE_W)*PC_W-1:0] PC_LAST  = {8'd0, 8'd27, 8'd15, 8'd4},
  parameter int WDOG_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        level,
  input  logic [MODE_W-1:0] mode,
  input  logic              start,
  input  logic              abort,
  input  logic              inst_done,
  output logic              inst_valid,
  output logic [PC_W-1:0]   pc,
  output logic [1:0]        level_reg,
  output logic              busy,
  output logic              valid,
  output logic              err
);

  state_t            r_state;
  logic [MODE_W-1:0] r_mode;
  logic              r_start;
  logic [PC_W-1:0]   r_pc;
  logic [1:0]        r_level;
  logic              r_inst_valid;
  logic              r_valid;
  logic              r_err;

  logic              w_start_pos;
  logic [PC_W-1:0]   w_entry;
  logic [PC_W-1:0]   w_last;
  logic              w_wdog_exp;

  assign w_start_pos = start & ~r_start;
  assign w_entry     = PC_W'(entry_of(TBL_MAX_W'(PC_ENTRY), int'(r_mode), PC_W));
  assign w_last      = PC_W'(last_of(TBL_MAX_W'(PC_LAST), int'(r_mode), PC_W));

`ifdef FRODO_SEQ_WDOG_EN
  frodo_seq_wdog #(.W(WDOG_W)) u_wdog (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (r_state == S_IF),
    .i_inc ((r_state == S_EX) && !inst_done),
    .o_exp (w_wdog_exp)
  );
`else
  // Watchdog absent: expiry can never fire and EX waits indefinitely.
  assign w_wdog_exp = &{WDOG_W{1'b0}};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_mode       <= '0;
      r_start      <= 1'b0;
      r_pc         <= '0;
      r_level      <= '0;
      r_inst_valid <= 1'b0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_start      <= start;
      r_inst_valid <= 1'b0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      // Abort pre-empts every transition, including completion, and raises no status pulse.
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_pc    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_level <= level;
            r_mode  <= mode;
            r_pc    <= '0;
            if (w_start_pos) r_state <= S_START;
          end
          S_START: begin
            if (w_entry > w_last) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_pc    <= w_entry;
              r_state <= S_IF;
            end
          end
          S_IF: begin
            r_inst_valid <= 1'b1;
            r_state      <= S_EX;
          end
          S_EX: begin
            if (inst_done) begin
              r_state <= S_FINISH;
            end else if (w_wdog_exp) begin
              r_err   <= 1'b1;
              r_pc    <= '0;
              r_state <= S_IDLE;
            end
          end
          S_FINISH: begin
            if (r_pc == w_last) begin
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_pc    <= r_pc + PC_W'(1);
              r_state <= S_IF;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign inst_valid = r_inst_valid;
  assign pc         = r_pc;
  assign level_reg  = r_level;
  assign busy       = (r_state != S_IDLE);
  assign valid      = r_valid;
  assign err        = r_err;

endmodule

// File: tb/tb_frodo_seq_ctrl.sv
// Bench for frodo_seq_ctrl: directed vector table, hand-written corner sequences and randomized programs
// checked against a program-level model (PC list per mode, cost of 3+delay cycles per instruction).
module tb_frodo_seq_ctrl;
  import frodo_seq_pkg::*;

  localparam int WDOG_W_TB = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] level = 2'd0;
  logic [1:0] mode = 2'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       inst_done = 1'b0;
  logic       inst_valid;
  logic [7:0] pc;
  logic [1:0] level_reg;
  logic       busy;
  logic       valid;
  logic       err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int ENT [4] = '{0, 8, 16, 255};
  int LST [4] = '{4, 15, 27, 0};

  typedef struct {
    int mode;
    int lvl;
    int max_dly;
    int abort_k;
    int hold;
    bit abort_start;
    bit spur;
    int exp_n;
    int exp_valid;
    int exp_err;
  } vec_t;

  vec_t tbl [8];

  frodo_seq_ctrl #(.WDOG_W(WDOG_W_TB)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .level      (level),
    .mode       (mode),
    .start      (start),
    .abort      (abort),
    .inst_done  (inst_done),
    .inst_valid (inst_valid),
    .pc         (pc),
    .level_reg  (level_reg),
    .busy       (busy),
    .valid      (valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One program launch driven and monitored cycle by cycle; expectations come from the program model.
  task automatic run_prog(input vec_t v, input string tag);
    int exp_pcs[$];
    int got_pcs[$];
    int dly[$];
    int tot, c0, cnt, k, abort_cyc, exit_cyc, d;
    int n_valid, n_err, v_cyc, e_cyc, lvl_bad, relaunch;
    bit done_run;
    tot = 0; n_valid = 0; n_err = 0; v_cyc = -1; e_cyc = -1;
    lvl_bad = 0; relaunch = 0; done_run = 0; abort_cyc = -1; exit_cyc = -1;
    if (ENT[v.mode] <= LST[v.mode]) begin
      for (int p = ENT[v.mode]; p <= LST[v.mode]; p++) begin
        if (v.abort_k >= 0 && p > ENT[v.mode] + v.abort_k) break;
        d = $urandom_range(v.max_dly, 0);
        exp_pcs.push_back(p);
        dly.push_back(d);
        tot += 3 + d;
      end
    end

    start = 1'b0; abort = 1'b0; inst_done = 1'b0;
    tick();
    level = 2'(v.lvl); mode = 2'(v.mode); start = 1'b1; abort = v.abort_start;
    c0 = cyc;
    tick();
    abort = 1'b0;
    level = ~2'(v.lvl);
    mode = 2'($urandom_range(3, 0));
    cnt = -1; k = 0;
    for (int i = 0; i < 600 && !done_run; i++) begin
      if (cyc - c0 >= v.hold) start = 1'b0;
      if (inst_valid) begin
        got_pcs.push_back(int'(pc));
        if (int'(level_reg) != v.lvl) lvl_bad++;
        cnt = (k < dly.size()) ? dly[k] : 0;
      end
      if (valid) begin n_valid++; v_cyc = cyc; end
      if (err) begin n_err++; e_cyc = cyc; end
      inst_done = 1'b0;
      abort = 1'b0;
      if (!busy) begin
        done_run = 1'b1;
        exit_cyc = cyc;
        if (v.abort_k >= 0) chk({tag, " pc_after_abort"}, int'(pc), 0);
      end else if (cnt == 0) begin
        inst_done = 1'b1;
        if (k == v.abort_k) begin abort = 1'b1; abort_cyc = cyc; end
        cnt = -1;
        k++;
      end else if (cnt > 0) begin
        cnt--;
      end else if (v.spur) begin
        inst_done = 1'($urandom_range(1, 0));
      end
      if (!done_run) tick();
    end
    inst_done = 1'b0;
    abort = 1'b0;
    chk({tag, " terminated"}, int'(done_run), 1);

    tick();
    chk({tag, " pc_cleared"}, int'(pc), 0);
    if (busy || inst_valid) relaunch++;
    while (cyc < c0 + v.hold + 3) begin
      start = (cyc - c0 < v.hold);
      tick();
      if (busy || inst_valid) relaunch++;
    end
    start = 1'b0;

    chk({tag, " n_inst"}, got_pcs.size(), v.exp_n);
    for (int i = 0; i < got_pcs.size() && i < exp_pcs.size(); i++)
      chk($sformatf("%s pc[%0d]", tag, i), got_pcs[i], exp_pcs[i]);
    chk({tag, " n_valid"}, n_valid, v.exp_valid);
    chk({tag, " n_err"}, n_err, v.exp_err);
    if (v.exp_valid != 0) chk({tag, " valid_cycle"}, v_cyc - c0, 2 + tot);
    if (v.exp_err != 0) chk({tag, " err_cycle"}, e_cyc - c0, 2);
    if (v.abort_k >= 0) chk({tag, " abort_latency"}, exit_cyc - abort_cyc, 1);
    chk({tag, " level_latched"}, lvl_bad, 0);
    chk({tag, " no_relaunch"}, relaunch, 0);
  endtask

  initial begin
    vec_t v;
    int c0, got_e, n_e, found, n_prog;

    tbl[0] = '{int'(MODE_KEYGEN), 1, 0, -1, 1,  1'b0, 1'b0, 5,  1, 0};
    tbl[1] = '{int'(MODE_ENCAP),  2, 0, -1, 40, 1'b0, 1'b0, 8,  1, 0};
    tbl[2] = '{3,                 3, 0, -1, 1,  1'b0, 1'b0, 0,  0, 1};
    tbl[3] = '{int'(MODE_DECAP),  0, 0, 4,  1,  1'b0, 1'b0, 5,  0, 0};
    tbl[4] = '{int'(MODE_KEYGEN), 3, 2, -1, 1,  1'b1, 1'b1, 5,  1, 0};
    tbl[5] = '{int'(MODE_ENCAP),  1, 0, 0,  1,  1'b0, 1'b0, 1,  0, 0};
    tbl[6] = '{int'(MODE_DECAP),  2, 1, -1, 1,  1'b0, 1'b1, 12, 1, 0};
    tbl[7] = '{int'(MODE_KEYGEN), 0, 0, 4,  1,  1'b0, 1'b0, 5,  0, 0};

    #2;
    chk("reset pc", int'(pc), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset inst_valid", int'(inst_valid), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset err", int'(err), 0);
    chk("reset level_reg", int'(level_reg), 0);
    #10 rstn = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 8; i++) run_prog(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted mid-EX at pc=10 clears everything immediately.
    start = 1'b0; tick();
    mode = 2'd1; level = 2'd1; start = 1'b1; tick(); start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (inst_valid && pc == 8'd10) found = 1;
      else begin inst_done = inst_valid; tick(); end
    end
    inst_done = 1'b0;
    chk("rst reach_pc10", found, 1);
    tick(); tick();
    chk("rst busy_before", int'(busy), 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst pc", int'(pc), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst level_reg", int'(level_reg), 0);
    chk("rst valid_err_iv", int'({valid, err, inst_valid}), 0);
    #2 rstn = 1'b1;
    tick();
    run_prog('{1, 2, 0, -1, 1, 1'b0, 1'b0, 8, 1, 0}, "post_rst");

`ifdef FRODO_SEQ_WDOG_EN
    // No inst_done ever: watchdog expires after 2**W-1 EX cycles.
    start = 1'b0; tick();
    mode = 2'd0; start = 1'b1; c0 = cyc; tick(); start = 1'b0;
    got_e = -1;
    for (int i = 0; i < (1 << WDOG_W_TB) + 40 && got_e < 0; i++) begin
      if (err) got_e = cyc;
      else tick();
    end
    chk("wdog err_cycle", got_e - c0, 3 + (1 << WDOG_W_TB) - 1);
    chk("wdog busy", int'(busy), 0);
    tick();
    chk("wdog pc", int'(pc), 0);
`else
    // No watchdog: EX waits indefinitely until aborted.
    start = 1'b0; tick();
    mode = 2'd2; start = 1'b1; tick(); start = 1'b0;
    n_e = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (err || valid) n_e++;
    end
    chk("nowdog still_busy", int'(busy), 1);
    chk("nowdog no_status", n_e, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("nowdog abort_busy", int'(busy), 0);
    chk("nowdog abort_pc", int'(pc), 0);
    tick();
    chk("nowdog abort_no_err", int'({err, valid}), 0);
`endif

    for (int r = 0; r < 25; r++) begin
      v.mode = $urandom_range(3, 0);
      v.lvl = $urandom_range(3, 0);
      v.max_dly = $urandom_range(3, 0);
      v.hold = $urandom_range(5, 1);
      v.abort_start = 1'($urandom_range(1, 0));
      v.spur = 1'b1;
      if (ENT[v.mode] <= LST[v.mode]) begin
        n_prog = LST[v.mode] - ENT[v.mode] + 1;
        v.abort_k = ($urandom_range(2, 0) == 0) ? $urandom_range(n_prog - 1, 0) : -1;
        v.exp_n = (v.abort_k >= 0) ? v.abort_k + 1 : n_prog;
        v.exp_valid = (v.abort_k >= 0) ? 0 : 1;
        v.exp_err = 0;
      end else begin
        v.abort_k = -1;
        v.exp_n = 0;
        v.exp_valid = 0;
        v.exp_err = 1;
      end
      run_prog(v, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
